// File: rtl/seg_pkg.sv
// Shared types and widths for the seven-segment display arbiter slice.
package seg_pkg;

   localparam int DIGITS = 6;
   localparam int NUM_W  = 4 * DIGITS;
   localparam int PT_W   = DIGITS;
   localparam int ID_W   = 3;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SHOW,
      ST_HOLD
   } disp_st_t;

endpackage

// File: rtl/seg_rr_pick.sv
// Combinational round-robin picker: returns the first eligible requester
// found when searching last+1, last+2, ... modulo N_REQ.
module seg_rr_pick
   import seg_pkg::*;
#(
   parameter int N_REQ = 3
) (
   input  logic [N_REQ-1:0] i_req,
   input  logic [N_REQ-1:0] i_mask,
   input  logic [ID_W-1:0]  i_last,
   output logic             o_valid,
   output logic [ID_W-1:0]  o_id
);

   int w_best;
   int w_dist;

   // Choose the eligible requester with the smallest rotational distance past 'last'.
   always_comb begin
      o_valid = 1'b0;
      o_id    = '0;
      w_best  = N_REQ;
      w_dist  = 0;
      for (int i = 0; i < N_REQ; i++) begin
         if (i_req[i] && i_mask[i]) begin
            w_dist = (i - int'(i_last) - 1 + 2 * N_REQ) % N_REQ;
            if (w_dist < w_best) begin
               w_best  = w_dist;
               o_valid = 1'b1;
               o_id    = ID_W'(i);
            end
         end
      end
   end

endmodule

// File: rtl/seg_disp_arbiter.sv
// Arbitrates the single 6-digit seven-segment driver between N_REQ requesters.
// Round-robin with a minimum dwell per grant; requester 0 preempts everyone else.
module seg_disp_arbiter
   import seg_pkg::*;
#(
   parameter int N_REQ     = 3,
   parameter int DWELL_CYC = 50_000_000,
   parameter int CNT_W     = 26
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [N_REQ-1:0]         req,
   input  logic [N_REQ*NUM_W-1:0]   req_num,
   input  logic [N_REQ*PT_W-1:0]    req_point,
   output logic [N_REQ-1:0]         gnt,
   output logic [ID_W-1:0]          gnt_id,
   output logic [NUM_W-1:0]         num,
   output logic [PT_W-1:0]          point,
   output logic                     disp_on
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL_CYC - 1);

   disp_st_t          r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic [ID_W-1:0]   r_last;
   logic [N_REQ-1:0]  r_gnt;
   logic [ID_W-1:0]   r_gnt_id;
   logic [NUM_W-1:0]  r_num;
   logic [PT_W-1:0]   r_point;

   logic [N_REQ-1:0]  w_all_mask;
   logic [N_REQ-1:0]  w_oth_mask;
   logic              w_idle_valid;
   logic [ID_W-1:0]   w_idle_id;
   logic              w_oth_valid;
   logic [ID_W-1:0]   w_oth_id;
   logic              w_own_req;
   logic              w_preempt;
   logic              w_expired;

   function automatic logic [N_REQ-1:0] oneHot(input logic [ID_W-1:0] id);
      logic [N_REQ-1:0] v;
      v = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (id == ID_W'(i)) v[i] = 1'b1;
      end
      return v;
   endfunction

   function automatic logic [NUM_W-1:0] selNum(input logic [ID_W-1:0] id,
                                                input logic [N_REQ*NUM_W-1:0] bus);
      logic [NUM_W-1:0] v;
      v = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (id == ID_W'(i)) v = bus[i*NUM_W +: NUM_W];
      end
      return v;
   endfunction

   function automatic logic [PT_W-1:0] selPoint(input logic [ID_W-1:0] id,
                                                 input logic [N_REQ*PT_W-1:0] bus);
      logic [PT_W-1:0] v;
      v = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (id == ID_W'(i)) v = bus[i*PT_W +: PT_W];
      end
      return v;
   endfunction

   assign w_all_mask = '1;
   assign w_oth_mask = ~r_gnt;
   assign w_own_req  = |(req & r_gnt);
   assign w_preempt  = req[0] && (r_gnt_id != '0);
   assign w_expired  = (r_cnt == CNT_LAST);

   // From IDLE any requester may win; search starts just past the last winner.
   seg_rr_pick #(.N_REQ(N_REQ)) u_pick_idle (
      .i_req   (req),
      .i_mask  (w_all_mask),
      .i_last  (r_last),
      .o_valid (w_idle_valid),
      .o_id    (w_idle_id)
   );

   // While someone owns the display, only the others count as pending.
   seg_rr_pick #(.N_REQ(N_REQ)) u_pick_other (
      .i_req   (req),
      .i_mask  (w_oth_mask),
      .i_last  (r_last),
      .o_valid (w_oth_valid),
      .o_id    (w_oth_id)
   );

   // Arbitration FSM with dwell counter and registered grant/data outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= ST_IDLE;
         r_cnt    <= '0;
         r_last   <= ID_W'(N_REQ - 1);
         r_gnt    <= '0;
         r_gnt_id <= '0;
         r_num    <= '0;
         r_point  <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_idle_valid) begin
                  r_gnt    <= oneHot(w_idle_id);
                  r_gnt_id <= w_idle_id;
                  r_num    <= selNum(w_idle_id, req_num);
                  r_point  <= selPoint(w_idle_id, req_point);
                  r_cnt    <= '0;
                  r_last   <= w_idle_id;
                  r_state  <= ST_SHOW;
               end
            end
            ST_SHOW: begin
               if (w_preempt) begin
                  r_gnt    <= oneHot('0);
                  r_gnt_id <= '0;
                  r_num    <= selNum('0, req_num);
                  r_point  <= selPoint('0, req_point);
                  r_cnt    <= '0;
                  r_last   <= '0;
               end else if (w_expired) begin
                  if (w_oth_valid) begin
                     r_gnt    <= oneHot(w_oth_id);
                     r_gnt_id <= w_oth_id;
                     r_num    <= selNum(w_oth_id, req_num);
                     r_point  <= selPoint(w_oth_id, req_point);
                     r_cnt    <= '0;
                     r_last   <= w_oth_id;
                  end else if (w_own_req) begin
                     r_num    <= selNum(r_gnt_id, req_num);
                     r_point  <= selPoint(r_gnt_id, req_point);
                     r_state  <= ST_HOLD;
                  end else begin
                     r_gnt    <= '0;
                     r_gnt_id <= '0;
                     r_num    <= '0;
                     r_point  <= '0;
                     r_state  <= ST_IDLE;
                  end
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
                  if (w_own_req) begin
                     r_num   <= selNum(r_gnt_id, req_num);
                     r_point <= selPoint(r_gnt_id, req_point);
                  end
               end
            end
            ST_HOLD: begin
               if (w_preempt) begin
                  r_gnt    <= oneHot('0);
                  r_gnt_id <= '0;
                  r_num    <= selNum('0, req_num);
                  r_point  <= selPoint('0, req_point);
                  r_cnt    <= '0;
                  r_last   <= '0;
                  r_state  <= ST_SHOW;
               end else if (w_oth_valid) begin
                  r_gnt    <= oneHot(w_oth_id);
                  r_gnt_id <= w_oth_id;
                  r_num    <= selNum(w_oth_id, req_num);
                  r_point  <= selPoint(w_oth_id, req_point);
                  r_cnt    <= '0;
                  r_last   <= w_oth_id;
                  r_state  <= ST_SHOW;
               end else if (w_own_req) begin
                  r_num   <= selNum(r_gnt_id, req_num);
                  r_point <= selPoint(r_gnt_id, req_point);
               end else begin
                  r_gnt    <= '0;
                  r_gnt_id <= '0;
                  r_num    <= '0;
                  r_point  <= '0;
                  r_state  <= ST_IDLE;
               end
            end
            default: begin
               r_gnt    <= '0;
               r_gnt_id <= '0;
               r_num    <= '0;
               r_point  <= '0;
               r_cnt    <= '0;
               r_state  <= ST_IDLE;
            end
         endcase
      end
   end

   assign gnt     = r_gnt;
   assign gnt_id  = r_gnt_id;
   assign num     = r_num;
   assign point   = r_point;
   assign disp_on = |r_gnt;

endmodule

// File: tb/tb_seg_disp_arbiter.sv
// Self-checking bench for seg_disp_arbiter: directed scenarios with literal
// expectations, then randomized traffic compared against a behavioural model.
module tb_seg_disp_arbiter;

   localparam int N_REQ = 3;
   localparam int DWELL = 4;
   localparam int CNT_W = 3;

   logic        clk;
   logic        rst_n;
   logic [2:0]  req;
   logic [71:0] req_num;
   logic [17:0] req_point;
   logic [2:0]  gnt;
   logic [2:0]  gnt_id;
   logic [23:0] num;
   logic [5:0]  point;
   logic        disp_on;

   int   nChecks;
   int   nFails;
   logic checkEn;

   // Model state: owner index (-1 when idle), cycles since grant, last winner, shown data.
   typedef struct packed {
      int          owner;
      int          age;
      int          last;
      logic [23:0] num;
      logic [5:0]  pt;
   } model_t;

   model_t      m;
   logic [2:0]  expGnt;
   logic [2:0]  expId;

   seg_disp_arbiter #(
      .N_REQ     (N_REQ),
      .DWELL_CYC (DWELL),
      .CNT_W     (CNT_W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .req_num   (req_num),
      .req_point (req_point),
      .gnt       (gnt),
      .gnt_id    (gnt_id),
      .num       (num),
      .point     (point),
      .disp_on   (disp_on)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic int rrPick(input logic [2:0] r, input int excl, input int lastIdx);
      for (int k = 1; k <= N_REQ; k++) begin
         int i;
         i = (lastIdx + k) % N_REQ;
         if (i != excl && ((r >> i) & 3'b001) != 3'b000) return i;
      end
      return -1;
   endfunction

   function automatic model_t grantTo(input model_t s, input int w);
      model_t n;
      n = s;
      n.owner = w;
      n.age   = 0;
      n.last  = w;
      n.num   = 24'(req_num >> (24 * w));
      n.pt    = 6'(req_point >> (6 * w));
      return n;
   endfunction

   function automatic model_t modelReset();
      model_t n;
      n.owner = -1;
      n.age   = 0;
      n.last  = N_REQ - 1;
      n.num   = '0;
      n.pt    = '0;
      return n;
   endfunction

   function automatic model_t modelStep(input model_t s);
      model_t n;
      int     w;
      logic   ownReq;
      n = s;
      if (s.owner < 0) begin
         w = rrPick(req, -1, s.last);
         if (w >= 0) n = grantTo(s, w);
      end else begin
         ownReq = ((req >> s.owner) & 3'b001) != 3'b000;
         if (req[0] && s.owner != 0) begin
            n = grantTo(s, 0);
         end else if (s.age >= DWELL - 1) begin
            w = rrPick(req, s.owner, s.last);
            if (w >= 0) begin
               n = grantTo(s, w);
            end else if (ownReq) begin
               n.num = 24'(req_num >> (24 * s.owner));
               n.pt  = 6'(req_point >> (6 * s.owner));
            end else begin
               n.owner = -1;
               n.age   = 0;
               n.num   = '0;
               n.pt    = '0;
            end
         end else begin
            n.age = s.age + 1;
            if (ownReq) begin
               n.num = 24'(req_num >> (24 * s.owner));
               n.pt  = 6'(req_point >> (6 * s.owner));
            end
         end
      end
      return n;
   endfunction

   // Advance the behavioural model on the same events that move the DUT.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) m <= modelReset();
      else        m <= modelStep(m);
   end

   // Expected grant vector and index derived from the model's owner.
   always_comb begin
      expGnt = 3'b000;
      expId  = 3'd0;
      if (m.owner >= 0) begin
         expGnt = 3'(1 << m.owner);
         expId  = 3'(m.owner);
      end
   end

   // Per-cycle comparison of every DUT output against the model, mid-cycle.
   initial begin
      forever begin
         @(negedge clk);
         if (checkEn) begin
            nChecks++;
            if ({gnt, gnt_id, num, point, disp_on} !== {expGnt, expId, m.num, m.pt, |expGnt}) begin
               nFails++;
               $display("[TB] FAIL model_compare t=%0t actual gnt=%b id=%0d num=%h point=%b on=%b required gnt=%b id=%0d num=%h point=%b on=%b",
                        $time, gnt, gnt_id, num, point, disp_on, expGnt, expId, m.num, m.pt, |expGnt);
            end
         end
      end
   end

   task automatic checkOutput(input string name, input logic [2:0] eg, input logic [2:0] eid,
                              input logic [23:0] en, input logic [5:0] ep, input logic eon);
      nChecks++;
      if ({gnt, gnt_id, num, point, disp_on} !== {eg, eid, en, ep, eon}) begin
         nFails++;
         $display("[TB] FAIL %s t=%0t actual gnt=%b id=%0d num=%h point=%b on=%b required gnt=%b id=%0d num=%h point=%b on=%b",
                  name, $time, gnt, gnt_id, num, point, disp_on, eg, eid, en, ep, eon);
      end
   endtask

   task automatic applyStimulus(input logic [2:0] r);
      req = r;
   endtask

   task automatic setSlot(input int i, input logic [23:0] n, input logic [5:0] p);
      req_num   = (req_num & ~(72'hFFFFFF << (24 * i))) | (72'(n) << (24 * i));
      req_point = (req_point & ~(18'h3F << (6 * i))) | (18'(p) << (6 * i));
   endtask

   initial begin
      logic [2:0]  eid;
      logic [2:0]  eg;
      logic [23:0] en;
      logic [5:0]  ep;
      logic [2:0]  r;

      nChecks   = 0;
      nFails    = 0;
      checkEn   = 1'b0;
      rst_n     = 1'b0;
      req       = '0;
      req_num   = '0;
      req_point = '0;

      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      checkOutput("reset_state", 3'b000, 3'd0, 24'h0, 6'b0, 1'b0);
      checkEn = 1'b1;

      // Single requester, then held beyond the dwell into HOLD with tracking.
      $display("[TB] single requester");
      setSlot(1, 24'h123456, 6'b000100);
      applyStimulus(3'b010);
      @(negedge clk);
      checkOutput("single_grant", 3'b010, 3'd1, 24'h123456, 6'b000100, 1'b1);
      repeat (6) @(negedge clk);
      checkOutput("single_hold", 3'b010, 3'd1, 24'h123456, 6'b000100, 1'b1);
      setSlot(1, 24'h654321, 6'b000100);
      @(negedge clk);
      checkOutput("hold_track", 3'b010, 3'd1, 24'h654321, 6'b000100, 1'b1);

      // Asynchronous reset between clock edges.
      $display("[TB] async reset");
      #2 rst_n = 1'b0;
      #1 checkOutput("async_reset", 3'b000, 3'd0, 24'h0, 6'b0, 1'b0);
      applyStimulus(3'b000);
      @(negedge clk);
      rst_n = 1'b1;

      // Round-robin alternation between requesters 1 and 2.
      $display("[TB] round robin");
      setSlot(2, 24'h000777, 6'b100000);
      applyStimulus(3'b110);
      for (int k = 0; k < 9; k++) begin
         @(negedge clk);
         eid = (k < 4 || k == 8) ? 3'd1 : 3'd2;
         eg  = (eid == 3'd1) ? 3'b010 : 3'b100;
         en  = (eid == 3'd1) ? 24'h654321 : 24'h000777;
         ep  = (eid == 3'd1) ? 6'b000100 : 6'b100000;
         checkOutput("rr_alternation", eg, eid, en, ep, 1'b1);
      end

      // Preemption by requester 0 while requester 2 is mid-dwell.
      $display("[TB] preemption");
      repeat (4) @(negedge clk);
      checkOutput("preempt_setup", 3'b100, 3'd2, 24'h000777, 6'b100000, 1'b1);
      @(negedge clk);
      setSlot(0, 24'h000999, 6'b000001);
      applyStimulus(3'b111);
      @(negedge clk);
      checkOutput("preempt", 3'b001, 3'd0, 24'h000999, 6'b000001, 1'b1);

      // Early drop: data freezes, grant kept until dwell expiry, then idle.
      $display("[TB] early drop");
      #2 rst_n = 1'b0;
      applyStimulus(3'b000);
      @(negedge clk);
      rst_n = 1'b1;
      setSlot(1, 24'h111111, 6'b010000);
      applyStimulus(3'b010);
      @(negedge clk);
      checkOutput("drop_grant", 3'b010, 3'd1, 24'h111111, 6'b010000, 1'b1);
      applyStimulus(3'b000);
      setSlot(1, 24'h222222, 6'b000010);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checkOutput("drop_frozen", 3'b010, 3'd1, 24'h111111, 6'b010000, 1'b1);
      end
      @(negedge clk);
      checkOutput("drop_expire_idle", 3'b000, 3'd0, 24'h0, 6'b0, 1'b0);

      // Preemption arriving on the same edge as expiry with requester 2 pending.
      $display("[TB] preempt versus expiry");
      applyStimulus(3'b010);
      @(negedge clk);
      checkOutput("sim_grant", 3'b010, 3'd1, 24'h222222, 6'b000010, 1'b1);
      applyStimulus(3'b110);
      repeat (3) @(negedge clk);
      applyStimulus(3'b111);
      @(negedge clk);
      checkOutput("preempt_vs_expiry", 3'b001, 3'd0, 24'h000999, 6'b000001, 1'b1);
      repeat (3) @(negedge clk);
      checkOutput("req0_dwell", 3'b001, 3'd0, 24'h000999, 6'b000001, 1'b1);
      @(negedge clk);
      checkOutput("req0_yields_rr", 3'b010, 3'd1, 24'h222222, 6'b000010, 1'b1);
      @(negedge clk);
      checkOutput("req0_repreempts", 3'b001, 3'd0, 24'h000999, 6'b000001, 1'b1);

      // Randomized traffic against the model, with occasional async resets.
      $display("[TB] random traffic");
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 99) < 30) begin
            r = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) != 0) r[0] = 1'b0;
            applyStimulus(r);
         end
         for (int i = 0; i < N_REQ; i++) begin
            if ($urandom_range(0, 1) == 1) setSlot(i, 24'($urandom), 6'($urandom));
         end
         if ($urandom_range(0, 199) == 0) begin
            #2 rst_n = 1'b0;
            #1 checkOutput("rand_async_reset", 3'b000, 3'd0, 24'h0, 6'b0, 1'b0);
            @(negedge clk);
            rst_n = 1'b1;
         end else begin
            @(negedge clk);
         end
      end

      checkEn = 1'b0;
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
